// File: rtl/instr_ctrl.sv
// Multi-cycle instruction controller: sequences FETCH/DECODE/EXEC/WB over an
// external ALU and PC stage, and owns the 16-entry register file.
module instr_ctrl #(
    parameter int word_size = 16,
    parameter int op_size   = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [word_size-1:0] pc_counter,
    output logic                 imem_req,
    output logic [word_size-1:0] imem_addr,
    input  logic [word_size-1:0] imem_rdata,
    input  logic                 imem_valid,
    output logic [op_size-1:0]   alu_sel,
    output logic [word_size-1:0] alu_a,
    output logic [word_size-1:0] alu_b,
    input  logic [word_size-1:0] alu_out,
    input  logic                 alu_zero_flag,
    output logic                 pc_inc,
    output logic                 load_pc,
    output logic [word_size-1:0] pc_data,
    output logic                 halted,
    input  logic [3:0]           dbg_sel,
    output logic [word_size-1:0] dbg_data
);

    localparam int rd_lsb = word_size - op_size - 4;

    localparam logic [op_size-1:0] op_alu_last = op_size'(7);
    localparam logic [op_size-1:0] op_ldi      = op_size'(8);
    localparam logic [op_size-1:0] op_bz       = op_size'(9);
    localparam logic [op_size-1:0] op_jmp      = op_size'(10);
    localparam logic [op_size-1:0] op_halt     = op_size'(15);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [word_size-1:0] ir;
    logic [word_size-1:0] result;
    logic [word_size-1:0] regs [16];

    logic [op_size-1:0]   op;
    logic [3:0]           rd;
    logic [3:0]           rs;
    logic [3:0]           rt;
    logic [word_size-1:0] rd_val;
    logic [word_size-1:0] rs_val;
    logic [word_size-1:0] rt_val;

    logic                 wb_we;
    logic [word_size-1:0] wb_val;
    logic                 take_inc;
    logic                 take_load;
    logic [word_size-1:0] load_target;

    logic unused_inputs;
    assign unused_inputs = alu_zero_flag;

    assign op = ir[word_size-1 -: op_size];
    assign rd = ir[rd_lsb +: 4];
    assign rs = ir[7:4];
    assign rt = ir[3:0];

    // r0 is hard-wired to zero on every read port.
    assign rd_val   = (rd == 4'd0)      ? '0 : regs[rd];
    assign rs_val   = (rs == 4'd0)      ? '0 : regs[rs];
    assign rt_val   = (rt == 4'd0)      ? '0 : regs[rt];
    assign dbg_data = (dbg_sel == 4'd0) ? '0 : regs[dbg_sel];

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc_counter;

    // NOTE: <= in every clocked block so all state updates see pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: state_nx gets its default before the case, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_FETCH:  if (imem_valid) state_nx = S_DECODE;
            S_DECODE: state_nx = (op == op_halt) ? S_HALT : S_EXEC;
            S_EXEC:   state_nx = S_WB;
            S_WB:     state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_FETCH;
        endcase
    end

    // Writeback and PC decisions; operands are stable from EXEC through WB.
    always_comb begin
        wb_we       = 1'b0;
        wb_val      = result;
        take_inc    = 1'b0;
        take_load   = 1'b0;
        load_target = '0;
        if (op <= op_alu_last) begin
            wb_we    = 1'b1;
            take_inc = 1'b1;
        end else if (op == op_ldi) begin
            wb_we    = 1'b1;
            wb_val   = word_size'(ir[7:0]);
            take_inc = 1'b1;
        end else if (op == op_bz) begin
            if (rd_val == '0) begin
                take_load   = 1'b1;
                load_target = pc_counter + {{(word_size-8){ir[7]}}, ir[7:0]};
            end else begin
                take_inc = 1'b1;
            end
        end else if (op == op_jmp) begin
            take_load   = 1'b1;
            load_target = word_size'(ir[word_size-op_size-1:0]);
        end else if (op != op_halt) begin
            take_inc = 1'b1;
        end
    end

    // PC pulses are registered on EXEC->WB so they are high for exactly the WB cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ir      <= '0;
            result  <= '0;
            alu_sel <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            pc_inc  <= 1'b0;
            load_pc <= 1'b0;
            pc_data <= '0;
            halted  <= 1'b0;
        end else begin
            pc_inc  <= 1'b0;
            load_pc <= 1'b0;
            halted  <= (state_nx == S_HALT);
            unique case (state)
                S_FETCH: begin
                    if (imem_valid) ir <= imem_rdata;
                end
                S_DECODE: begin
                    alu_sel <= op;
                    alu_a   <= rs_val;
                    alu_b   <= rt_val;
                end
                S_EXEC: begin
                    result  <= alu_out;
                    pc_inc  <= take_inc;
                    load_pc <= take_load;
                    if (take_load) pc_data <= load_target;
                end
                default: begin
                end
            endcase
        end
    end

    // NOTE: the register file is reset because software may rely on all registers reading 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (state == S_WB && wb_we && rd != 4'd0) begin
            regs[rd] <= wb_val;
        end
    end

    a_pulse_exclusive: assert property (@(posedge clk) disable iff (!rstn)
        !(pc_inc && load_pc));

    a_pulse_only_in_wb: assert property (@(posedge clk) disable iff (!rstn)
        (pc_inc || load_pc) |-> (state == S_WB));

endmodule

// File: tb/tb_instr_ctrl.sv
// Self-checking bench for instr_ctrl: directed scenarios plus randomized
// instruction streams against an ISA-level register/PC model.
module tb_instr_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] pc_counter;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [3:0]  alu_sel;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_out;
    logic        alu_zero_flag;
    logic        pc_inc;
    logic        load_pc;
    logic [15:0] pc_data;
    logic        halted;
    logic [3:0]  dbg_sel;
    logic [15:0] dbg_data;

    int tests_run    = 0;
    int tests_failed = 0;

    instr_ctrl #(.word_size(16), .op_size(4)) dut (
        .clk(clk), .rstn(rstn), .pc_counter(pc_counter),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_valid(imem_valid), .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero_flag(alu_zero_flag), .pc_inc(pc_inc),
        .load_pc(load_pc), .pc_data(pc_data), .halted(halted),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // External ALU used by the controller.
    function automatic logic [15:0] alu_fn(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b);
        case (sel)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            4'h5:    return a << b[3:0];
            4'h6:    return a >> b[3:0];
            4'h7:    return (a < b) ? 16'h0001 : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_out       = alu_fn(alu_sel, alu_a, alu_b);
    assign alu_zero_flag = (alu_out == 16'h0000);

    // PC stage, with a bench-side override for placing the PC.
    logic        pc_force     = 1'b1;
    logic [15:0] pc_force_val = 16'h0000;
    int inc_cnt  = 0;
    int load_cnt = 0;
    int both_cnt = 0;

    always @(posedge clk) begin
        if (pc_force)     pc_counter <= pc_force_val;
        else if (pc_inc)  pc_counter <= pc_counter + 16'd1;
        else if (load_pc) pc_counter <= pc_data;
        if (pc_inc)            inc_cnt  <= inc_cnt + 1;
        if (load_pc)           load_cnt <= load_cnt + 1;
        if (pc_inc && load_pc) both_cnt <= both_cnt + 1;
    end

    // ISA-level reference model.
    logic [15:0] m_reg [16];
    logic        e_inc, e_load, e_we;
    logic [15:0] e_pc_data, e_wval, e_a, e_b, e_old, e_new;

    function automatic logic [15:0] m_read(input logic [3:0] idx);
        return (idx == 4'd0) ? 16'h0000 : m_reg[idx];
    endfunction

    task automatic predict(input logic [15:0] instr, input logic [15:0] pc);
        logic [3:0] op, rd, rs, rt;
        op = instr[15:12]; rd = instr[11:8]; rs = instr[7:4]; rt = instr[3:0];
        e_a = m_read(rs); e_b = m_read(rt); e_old = m_read(rd);
        e_inc = 1'b0; e_load = 1'b0; e_we = 1'b0; e_wval = 16'h0; e_pc_data = 16'h0;
        if (op <= 4'h7) begin
            e_we = 1'b1; e_wval = alu_fn(op, e_a, e_b); e_inc = 1'b1;
        end else if (op == 4'h8) begin
            e_we = 1'b1; e_wval = {8'h00, instr[7:0]}; e_inc = 1'b1;
        end else if (op == 4'h9) begin
            if (e_old == 16'h0000) begin
                e_load = 1'b1; e_pc_data = pc + {{8{instr[7]}}, instr[7:0]};
            end else begin
                e_inc = 1'b1;
            end
        end else if (op == 4'hA) begin
            e_load = 1'b1; e_pc_data = {4'h0, instr[11:0]};
        end else if (op != 4'hF) begin
            e_inc = 1'b1;
        end
        if (e_we && rd != 4'd0) m_reg[rd] = e_wval;
        e_new = m_read(rd);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
    endtask

    // Observations of one instruction; tasks start and end on a falling edge.
    logic        o_req_held, o_req_decode, o_req_after, o_halted, o_inc, o_load;
    logic [3:0]  o_sel;
    logic [15:0] o_a, o_b, o_pc_data, o_dbg_old, o_dbg_new, o_addr, o_pc;
    int          o_n_inc, o_n_load;

    task automatic do_instr(input logic [15:0] instr, input int waits, input bit abort_exec);
        int base_inc, base_load, guard;
        guard = 0;
        while (!imem_req && guard < 20) begin
            @(posedge clk); @(negedge clk); guard++;
        end
        tests_run++;
        if (imem_req !== 1'b1) begin
            tests_failed++; $display("FAIL fetch_timeout: imem_req=%b after %0d cycles, required 1", imem_req, guard);
        end
        dbg_sel    = instr[11:8];
        base_inc   = inc_cnt;
        base_load  = load_cnt;
        o_addr     = imem_addr;
        o_pc       = pc_counter;
        o_req_held = 1'b1;
        for (int i = 0; i < waits; i++) begin
            imem_valid = 1'b0; imem_rdata = 16'($urandom);
            @(posedge clk); @(negedge clk);
            if (imem_req !== 1'b1) o_req_held = 1'b0;
        end
        imem_valid = 1'b1; imem_rdata = instr;
        @(posedge clk); @(negedge clk);
        imem_valid = 1'b0; imem_rdata = 16'($urandom);
        o_req_decode = imem_req;
        @(posedge clk); @(negedge clk);
        o_sel = alu_sel; o_a = alu_a; o_b = alu_b; o_halted = halted;
        o_inc = pc_inc; o_load = load_pc;
        if (abort_exec) begin
            rstn = 1'b0;
            return;
        end
        if (instr[15:12] == 4'hF) return;
        @(posedge clk); @(negedge clk);
        o_inc = pc_inc; o_load = load_pc; o_pc_data = pc_data; o_dbg_old = dbg_data;
        @(posedge clk); @(negedge clk);
        o_req_after = imem_req; o_dbg_new = dbg_data;
        o_n_inc = inc_cnt - base_inc; o_n_load = load_cnt - base_load;
    endtask

    task automatic set_pc(input logic [15:0] val);
        pc_force = 1'b1; pc_force_val = val;
        @(posedge clk); @(negedge clk);
        pc_force = 1'b0;
    endtask

    task automatic run_model(input logic [15:0] instr, input int waits);
        predict(instr, pc_counter);
        do_instr(instr, waits, 1'b0);
    endtask

    task automatic test_reset();
        rstn = 1'b0; imem_valid = 1'b0; imem_rdata = 16'h0; dbg_sel = 4'd0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++; if (pc_inc !== 1'b0)   begin tests_failed++; $display("FAIL rst_pc_inc: got %b want 0", pc_inc); end
        tests_run++; if (load_pc !== 1'b0)  begin tests_failed++; $display("FAIL rst_load_pc: got %b want 0", load_pc); end
        tests_run++; if (pc_data !== 16'h0) begin tests_failed++; $display("FAIL rst_pc_data: got %h want 0000", pc_data); end
        tests_run++; if (alu_sel !== 4'h0)  begin tests_failed++; $display("FAIL rst_alu_sel: got %h want 0", alu_sel); end
        tests_run++; if (alu_a !== 16'h0)   begin tests_failed++; $display("FAIL rst_alu_a: got %h want 0000", alu_a); end
        tests_run++; if (alu_b !== 16'h0)   begin tests_failed++; $display("FAIL rst_alu_b: got %h want 0000", alu_b); end
        tests_run++; if (halted !== 1'b0)   begin tests_failed++; $display("FAIL rst_halted: got %b want 0", halted); end
        for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i);
            @(posedge clk); @(negedge clk);
            tests_run++; if (dbg_data !== 16'h0) begin tests_failed++; $display("FAIL rst_reg%0d: got %h want 0000", i, dbg_data); end
        end
        pc_force = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        tests_run++; if (imem_req !== 1'b1)     begin tests_failed++; $display("FAIL rst_release_req: got %b want 1", imem_req); end
        tests_run++; if (imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL rst_release_addr: got %h want 0000", imem_addr); end
    endtask

    task automatic test_ldi();
        run_model(16'h8135, 0);
        tests_run++; if (o_req_decode !== 1'b0) begin tests_failed++; $display("FAIL ldi_req_decode: got %b want 0", o_req_decode); end
        tests_run++; if (o_inc !== 1'b1)        begin tests_failed++; $display("FAIL ldi_wb_pc_inc: got %b want 1", o_inc); end
        tests_run++; if (o_load !== 1'b0)       begin tests_failed++; $display("FAIL ldi_wb_load_pc: got %b want 0", o_load); end
        tests_run++; if (o_n_inc !== 1)         begin tests_failed++; $display("FAIL ldi_inc_count: got %0d want 1", o_n_inc); end
        tests_run++; if (o_dbg_old !== 16'h0)   begin tests_failed++; $display("FAIL ldi_read_old_in_wb: got %h want 0000", o_dbg_old); end
        tests_run++; if (o_dbg_new !== 16'h0035) begin tests_failed++; $display("FAIL ldi_reg1: got %h want 0035", o_dbg_new); end
        tests_run++; if (o_req_after !== 1'b1)  begin tests_failed++; $display("FAIL ldi_back_to_fetch: got %b want 1", o_req_after); end
        tests_run++; if (pc_counter !== o_pc + 16'd1) begin tests_failed++; $display("FAIL ldi_pc: got %h want %h", pc_counter, o_pc + 16'd1); end
    endtask

    task automatic test_alu();
        run_model({8'h81, 8'($urandom)}, 0);
        run_model({8'h82, 8'($urandom)}, 0);
        run_model(16'h2312, 0);
        tests_run++; if (o_sel !== 4'h2)      begin tests_failed++; $display("FAIL alu_sel: got %h want 2", o_sel); end
        tests_run++; if (o_a !== m_reg[1])    begin tests_failed++; $display("FAIL alu_a: got %h want %h", o_a, m_reg[1]); end
        tests_run++; if (o_b !== m_reg[2])    begin tests_failed++; $display("FAIL alu_b: got %h want %h", o_b, m_reg[2]); end
        tests_run++; if (o_dbg_new !== (m_reg[1] & m_reg[2])) begin tests_failed++; $display("FAIL alu_reg3: got %h want %h", o_dbg_new, m_reg[1] & m_reg[2]); end
        tests_run++; if (o_n_inc !== 1)       begin tests_failed++; $display("FAIL alu_inc_count: got %0d want 1", o_n_inc); end
    endtask

    task automatic test_fetch_wait();
        run_model(16'h8A5C, 3);
        tests_run++; if (o_req_held !== 1'b1)  begin tests_failed++; $display("FAIL wait_req_held: got %b want 1", o_req_held); end
        tests_run++; if (o_addr !== o_pc)      begin tests_failed++; $display("FAIL wait_addr: got %h want %h", o_addr, o_pc); end
        tests_run++; if (o_dbg_new !== 16'h005C) begin tests_failed++; $display("FAIL wait_reg10: got %h want 005c", o_dbg_new); end
        tests_run++; if (o_n_inc !== 1)        begin tests_failed++; $display("FAIL wait_inc_count: got %0d want 1", o_n_inc); end
    endtask

    task automatic test_r0_discard();
        run_model(16'h80AB, 0);
        tests_run++; if (o_dbg_new !== 16'h0) begin tests_failed++; $display("FAIL r0_ldi: got %h want 0000", o_dbg_new); end
        run_model(16'h0011, 0);
        tests_run++; if (o_dbg_new !== 16'h0) begin tests_failed++; $display("FAIL r0_alu: got %h want 0000", o_dbg_new); end
        tests_run++; if (o_n_inc !== 1)       begin tests_failed++; $display("FAIL r0_inc_count: got %0d want 1", o_n_inc); end
    endtask

    task automatic test_branch();
        logic [15:0] pc0;
        set_pc(16'h0010);
        run_model(16'h90FE, 0);
        tests_run++; if (o_load !== 1'b1)        begin tests_failed++; $display("FAIL bz_taken_load: got %b want 1", o_load); end
        tests_run++; if (o_inc !== 1'b0)         begin tests_failed++; $display("FAIL bz_taken_inc: got %b want 0", o_inc); end
        tests_run++; if (o_pc_data !== 16'h000E) begin tests_failed++; $display("FAIL bz_taken_target: got %h want 000e", o_pc_data); end
        tests_run++; if (o_n_load !== 1 || o_n_inc !== 0) begin tests_failed++; $display("FAIL bz_taken_pulses: got load=%0d inc=%0d want 1/0", o_n_load, o_n_inc); end
        tests_run++; if (pc_counter !== 16'h000E) begin tests_failed++; $display("FAIL bz_taken_pc: got %h want 000e", pc_counter); end
        run_model(16'h8501, 0);
        pc0 = pc_counter;
        run_model(16'h95FE, 0);
        tests_run++; if (o_inc !== 1'b1 || o_load !== 1'b0) begin tests_failed++; $display("FAIL bz_not_taken: got inc=%b load=%b want 1/0", o_inc, o_load); end
        tests_run++; if (pc_counter !== pc0 + 16'd1) begin tests_failed++; $display("FAIL bz_not_taken_pc: got %h want %h", pc_counter, pc0 + 16'd1); end
        set_pc(16'h0000);
        run_model(16'h90FF, 0);
        tests_run++; if (o_pc_data !== 16'hFFFF) begin tests_failed++; $display("FAIL bz_wrap_target: got %h want ffff", o_pc_data); end
        run_model(16'hA123, 0);
        tests_run++; if (o_load !== 1'b1 || o_pc_data !== 16'h0123) begin tests_failed++; $display("FAIL jmp: got load=%b data=%h want 1/0123", o_load, o_pc_data); end
        run_model(16'hB5FF, 0);
        tests_run++; if (o_inc !== 1'b1 || o_dbg_new !== 16'h0001) begin tests_failed++; $display("FAIL nop: got inc=%b reg5=%h want 1/0001", o_inc, o_dbg_new); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] instr, pc0, pc_exp;
        for (int r = 1; r < 16; r++) run_model({4'h8, 4'(r), 8'($urandom)}, 0);
        for (int n = 0; n < 60; n++) begin
            instr = {4'($urandom_range(0, 14)), 12'($urandom)};
            pc0 = pc_counter;
            predict(instr, pc0);
            do_instr(instr, int'($urandom_range(0, 2)), 1'b0);
            pc_exp = e_load ? e_pc_data : pc0 + 16'd1;
            tests_run++; if (o_sel !== instr[15:12]) begin tests_failed++; $display("FAIL rnd_alu_sel #%0d: got %h want %h", n, o_sel, instr[15:12]); end
            tests_run++; if (o_a !== e_a || o_b !== e_b) begin tests_failed++; $display("FAIL rnd_operands #%0d: got %h/%h want %h/%h", n, o_a, o_b, e_a, e_b); end
            tests_run++; if (o_inc !== e_inc || o_load !== e_load) begin tests_failed++; $display("FAIL rnd_pulse #%0d instr %h: got inc=%b load=%b want %b/%b", n, instr, o_inc, o_load, e_inc, e_load); end
            if (e_load) begin
                tests_run++; if (o_pc_data !== e_pc_data) begin tests_failed++; $display("FAIL rnd_pc_data #%0d: got %h want %h", n, o_pc_data, e_pc_data); end
            end
            tests_run++; if (o_dbg_old !== e_old) begin tests_failed++; $display("FAIL rnd_dbg_old #%0d: got %h want %h", n, o_dbg_old, e_old); end
            tests_run++; if (o_dbg_new !== e_new) begin tests_failed++; $display("FAIL rnd_reg #%0d instr %h: got %h want %h", n, instr, o_dbg_new, e_new); end
            tests_run++; if (o_n_inc + o_n_load !== 1) begin tests_failed++; $display("FAIL rnd_pulse_count #%0d: got %0d want 1", n, o_n_inc + o_n_load); end
            tests_run++; if (pc_counter !== pc_exp) begin tests_failed++; $display("FAIL rnd_pc #%0d: got %h want %h", n, pc_counter, pc_exp); end
        end
    endtask

    task automatic test_reset_mid();
        int base_inc, base_load;
        run_model(16'hA0F0, 0);
        run_model(16'h8455, 0);
        base_inc = inc_cnt; base_load = load_cnt;
        do_instr(16'h8477, 0, 1'b1);
        #1;
        tests_run++; if (dbg_data !== 16'h0) begin tests_failed++; $display("FAIL abort_reg4: got %h want 0000", dbg_data); end
        tests_run++; if (pc_inc !== 1'b0 || load_pc !== 1'b0) begin tests_failed++; $display("FAIL abort_pulses: got inc=%b load=%b want 0/0", pc_inc, load_pc); end
        tests_run++; if (pc_data !== 16'h0)  begin tests_failed++; $display("FAIL abort_pc_data: got %h want 0000", pc_data); end
        tests_run++; if (alu_sel !== 4'h0 || alu_a !== 16'h0 || alu_b !== 16'h0) begin tests_failed++; $display("FAIL abort_alu: got %h/%h/%h want 0/0000/0000", alu_sel, alu_a, alu_b); end
        tests_run++; if (halted !== 1'b0)    begin tests_failed++; $display("FAIL abort_halted: got %b want 0", halted); end
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tests_run++; if (inc_cnt != base_inc || load_cnt != base_load) begin tests_failed++; $display("FAIL abort_no_pulse: got %0d extra pulses want 0", (inc_cnt - base_inc) + (load_cnt - base_load)); end
        @(negedge clk);
        tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL abort_restart_req: got %b want 1", imem_req); end
        run_model(16'h8135, 0);
        tests_run++; if (o_dbg_new !== 16'h0035) begin tests_failed++; $display("FAIL abort_restart_ldi: got %h want 0035", o_dbg_new); end
    endtask

    task automatic test_halt();
        int base_inc, base_load;
        run_model(16'hF000, 0);
        tests_run++; if (o_halted !== 1'b1) begin tests_failed++; $display("FAIL halt_entered: got %b want 1", o_halted); end
        tests_run++; if (o_inc !== 1'b0 || o_load !== 1'b0) begin tests_failed++; $display("FAIL halt_pulse: got inc=%b load=%b want 0/0", o_inc, o_load); end
        base_inc = inc_cnt; base_load = load_cnt;
        for (int i = 0; i < 10; i++) begin
            imem_valid = 1'b1; imem_rdata = 16'h8135;
            @(posedge clk); @(negedge clk);
            tests_run++; if (imem_req !== 1'b0 || halted !== 1'b1) begin tests_failed++; $display("FAIL halt_hold cycle %0d: got req=%b halted=%b want 0/1", i, imem_req, halted); end
        end
        imem_valid = 1'b0;
        tests_run++; if (inc_cnt != base_inc || load_cnt != base_load) begin tests_failed++; $display("FAIL halt_no_pulse: got %0d pulses want 0", (inc_cnt - base_inc) + (load_cnt - base_load)); end
        rstn = 1'b0;
        #1;
        tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL halt_reset: got %b want 0", halted); end
        clear_model();
        @(posedge clk); @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL halt_restart_req: got %b want 1", imem_req); end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_alu();
        test_fetch_wait();
        test_r0_discard();
        test_branch();
        test_back_to_back();
        test_reset_mid();
        test_halt();
        tests_run++; if (both_cnt != 0) begin tests_failed++; $display("FAIL pulse_overlap: got %0d cycles with both pulses want 0", both_cnt); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

endmodule
